// File: rtl/operacao_logica_pkg.sv
// Shared definitions for the serial bitwise logic unit: opcodes, FSM
// states and the default slice width.
package operacao_logica_pkg;

    localparam logic [2:0] OP_NOT  = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_NAND = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_XNOR = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    localparam int SLICE_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/operacao_logica_fatia.sv
// Combinational SLICE-bit logic unit; the serial top reuses one copy of
// it for every slice of the operands.
module operacao_logica_fatia
    import operacao_logica_pkg::*;
#(
    parameter int SLICE = SLICE_DEF
) (
    input  logic [2:0]       op,
    input  logic [SLICE-1:0] a_s,
    input  logic [SLICE-1:0] b_s,
    output logic [SLICE-1:0] y_s
);

    // Opcode decode; b_s is a don't-care for NOT and PASS
    always_comb begin
        y_s = a_s;
        case (op)
            OP_NOT:  y_s = ~a_s;
            OP_AND:  y_s = a_s & b_s;
            OP_OR:   y_s = a_s | b_s;
            OP_XOR:  y_s = a_s ^ b_s;
            OP_NAND: y_s = ~(a_s & b_s);
            OP_NOR:  y_s = ~(a_s | b_s);
            OP_XNOR: y_s = ~(a_s ^ b_s);
            default: y_s = a_s;
        endcase
    end

endmodule

// File: rtl/operacao_logica_serial.sv
// Serial bitwise logic unit: latches two WIDTH-bit operands and an opcode,
// then produces the result one SLICE-bit slice per clock.
// Optional feature macro: OPERACAO_LOGICA_PARIDADE_EN adds a parity output
// (XOR-reduction of y) accumulated slice by slice.
module operacao_logica_serial
    import operacao_logica_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SLICE = SLICE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero
`ifdef OPERACAO_LOGICA_PARIDADE_EN
    ,
    output logic             parity
`endif
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (WIDTH <= 0 || (WIDTH % SLICE) != 0) begin : g_bad_width
        $error("operacao_logica_serial: WIDTH must be a positive multiple of SLICE");
    end

    state_e                     state_q, state_d;
    logic [N-1:0][SLICE-1:0]    a_q, a_d, b_q, b_d, y_q, y_d;
    logic [2:0]                 op_q, op_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       zero_q, zero_d;
    logic [SLICE-1:0]           ys;
`ifdef OPERACAO_LOGICA_PARIDADE_EN
    logic                       parity_q, parity_d;
`endif

    // Single shared slice unit, fed the slice selected by the counter
    operacao_logica_fatia #(.SLICE(SLICE)) u_fatia (
        .op  (op_q),
        .a_s (a_q[cnt_q]),
        .b_s (b_q[cnt_q]),
        .y_s (ys)
    );

    // State and datapath registers; reset clears everything at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            y_q      <= '0;
            cnt_q    <= '0;
            zero_q   <= 1'b0;
`ifdef OPERACAO_LOGICA_PARIDADE_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            y_q      <= y_d;
            cnt_q    <= cnt_d;
            zero_q   <= zero_d;
`ifdef OPERACAO_LOGICA_PARIDADE_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next-state, slice write-back and handshake outputs
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        y_d       = y_q;
        cnt_d     = cnt_q;
        zero_d    = zero_q;
`ifdef OPERACAO_LOGICA_PARIDADE_EN
        parity_d  = parity_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    y_d     = '0;
                    cnt_d   = '0;
                    zero_d  = 1'b0;
`ifdef OPERACAO_LOGICA_PARIDADE_EN
                    parity_d = 1'b0;
`endif
                    state_d = PROC;
                end
            end
            PROC: begin
                y_d[cnt_q] = ys;
`ifdef OPERACAO_LOGICA_PARIDADE_EN
                parity_d = parity_q ^ (^ys);
`endif
                if (cnt_q == CW'(N - 1)) begin
                    // Counter parked at 0 so it never indexes past the last slice
                    cnt_d   = '0;
                    zero_d  = (y_d == '0);
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign y      = y_q;
    assign zero   = zero_q;
`ifdef OPERACAO_LOGICA_PARIDADE_EN
    assign parity = parity_q;
`endif

endmodule

// File: tb/tb_operacao_logica_serial.sv
// Scoreboard bench for operacao_logica_serial (8-bit instance plus a
// 16-bit instance for the wider directed case).
module tb_operacao_logica_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, in_valid, in_ready, out_valid, out_ready, zero;
    logic [7:0] a, b, y;
    logic [2:0] op;
    logic        v_in_valid, v_in_ready, v_out_valid, v_out_ready, v_zero;
    logic [15:0] va, vb, vy;
    logic [2:0]  vop;
`ifdef OPERACAO_LOGICA_PARIDADE_EN
    logic parity, vparity;
`endif

    operacao_logica_serial #(.WIDTH(8), .SLICE(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .zero(zero)
`ifdef OPERACAO_LOGICA_PARIDADE_EN
        , .parity(parity)
`endif
    );

    operacao_logica_serial #(.WIDTH(16), .SLICE(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(v_in_valid), .in_ready(v_in_ready),
        .a(va), .b(vb), .op(vop), .out_valid(v_out_valid), .out_ready(v_out_ready),
        .y(vy), .zero(v_zero)
`ifdef OPERACAO_LOGICA_PARIDADE_EN
        , .parity(vparity)
`endif
    );

    typedef struct {
        logic [7:0] y;
        logic       z;
        logic       p;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: bitwise operation on whole words, straight from the opcode table
    function automatic logic [15:0] ref_op(input logic [2:0] o, input logic [15:0] x, input logic [15:0] w);
        case (o)
            3'd0:    return ~x;
            3'd1:    return x & w;
            3'd2:    return x | w;
            3'd3:    return x ^ w;
            3'd4:    return ~(x & w);
            3'd5:    return ~(x | w);
            3'd6:    return ~(x ^ w);
            default: return x;
        endcase
    endfunction

    // Monitor: every completed output handshake is matched against the queue
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got y=%0h expected none", y);
            end else begin
                e = sbq.pop_front();
                check("sb_y", 32'(y), 32'(e.y));
                check("sb_zero", 32'(zero), 32'(e.z));
`ifdef OPERACAO_LOGICA_PARIDADE_EN
                check("sb_parity", 32'(parity), 32'(e.p));
`endif
            end
        end
    end

    task automatic do_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] w,
                         input int hold, input bit clr_in);
        exp_t        e;
        logic [15:0] full;
        logic [7:0]  r;
        int          lat;
        full = ref_op(o, {8'h00, x}, {8'h00, w});
        r    = full[7:0];
        @(negedge clk);
        op = o; a = x; b = w; in_valid = 1'b1;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk);
        e.y = r; e.z = (r == 8'h00); e.p = ^r;
        sbq.push_back(e);
        lat = 0;
        while (lat < 20) begin
            #1;
            // Inputs wander after accept; none of it may reach the result
            in_valid = 1'($urandom_range(0, 1));
            if (clr_in) begin
                a = 8'h00; b = 8'h00;
            end else begin
                a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
            end
            if (out_valid) break;
            @(posedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'd2);
        repeat (hold) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_y", 32'(y), 32'(r));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("valid_drop", 32'(out_valid), 32'd0);
        check("in_ready_back", 32'(in_ready), 32'd1);
        check("y_held_idle", 32'(y), 32'(r));
    endtask

    logic [7:0] tbl [8];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int lat;
        tbl = '{8'h35, 8'h48, 8'hEE, 8'hA6, 8'hB7, 8'h11, 8'h59, 8'hCA};
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
        v_in_valid = 1'b0; v_out_ready = 1'b0; va = '0; vb = '0; vop = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        rst = 1'b0;

        do_op(3'b000, 8'h3C, 8'h00, 0, 0);
        check("not_3c", 32'(y), 32'hC3);
        check("not_3c_zero", 32'(zero), 32'd0);
        do_op(3'b001, 8'hF0, 8'h0F, 5, 0);
        check("and_zero", 32'(zero), 32'd1);
        do_op(3'b011, 8'hA5, 8'hFF, 0, 1);
        check("xor_inputs_changed", 32'(y), 32'h5A);
        for (int i = 0; i < 8; i++) begin
            do_op(3'(i), 8'hCA, 8'h6C, 0, 0);
            check($sformatf("op_table_%0d", i), 32'(y), 32'(tbl[i]));
        end

        // Reset during processing: partial result discarded at once
        @(negedge clk);
        op = 3'b011; a = 8'hA5; b = 8'hFF; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1; #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_y", 32'(y), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk); rst = 1'b0;
        do_op(3'b010, 8'h12, 8'h40, 1, 0);

        repeat (40) do_op(3'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 3), 0);

        // 16-bit instance: four processing cycles
        @(negedge clk);
        vop = 3'b010; va = 16'h1200; vb = 16'h0034; v_in_valid = 1'b1;
        @(posedge clk); #1; v_in_valid = 1'b0;
        lat = 0;
        while (!v_out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check("w16_latency", 32'(lat), 32'd4);
        check("w16_y", 32'(vy), 32'h1234);
        check("w16_zero", 32'(v_zero), 32'd0);
`ifdef OPERACAO_LOGICA_PARIDADE_EN
        check("w16_parity", 32'(vparity), 32'd1);
`endif
        v_out_ready = 1'b1;
        @(posedge clk); #1; v_out_ready = 1'b0;
        check("w16_valid_drop", 32'(v_out_valid), 32'd0);

        repeat (2) @(negedge clk);
        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
